// File: rtl/exception_ctrl_pkg.sv
// rtl/exception_ctrl_pkg.sv - cause codes, flag indices, FSM states and flag->cause table
package exception_ctrl_pkg;

    localparam int EXC_CAUSE_W = 6;
    localparam int N_EXC_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVENT    = 2'd1,
        ST_REDIRECT = 2'd2
    } exc_state_e;

    localparam logic [EXC_CAUSE_W-1:0] EXCEPTION_INT  = 6'h00;
    localparam logic [EXC_CAUSE_W-1:0] EXCEPTION_PIL  = 6'h01;
    localparam logic [EXC_CAUSE_W-1:0] EXCEPTION_PIS  = 6'h02;
    localparam logic [EXC_CAUSE_W-1:0] EXCEPTION_PIF  = 6'h03;
    localparam logic [EXC_CAUSE_W-1:0] EXCEPTION_PME  = 6'h04;
    localparam logic [EXC_CAUSE_W-1:0] EXCEPTION_PPI  = 6'h07;
    localparam logic [EXC_CAUSE_W-1:0] EXCEPTION_ADE  = 6'h08;
    localparam logic [EXC_CAUSE_W-1:0] EXCEPTION_ALE  = 6'h09;
    localparam logic [EXC_CAUSE_W-1:0] EXCEPTION_SYS  = 6'h0b;
    localparam logic [EXC_CAUSE_W-1:0] EXCEPTION_BRK  = 6'h0c;
    localparam logic [EXC_CAUSE_W-1:0] EXCEPTION_INE  = 6'h0d;
    localparam logic [EXC_CAUSE_W-1:0] EXCEPTION_IPE  = 6'h0e;
    localparam logic [EXC_CAUSE_W-1:0] EXCEPTION_FPD  = 6'h0f;
    localparam logic [EXC_CAUSE_W-1:0] EXCEPTION_TLBR = 6'h3f;

    // Flag order follows pipeline order: fetch-stage faults outrank decode, decode outranks memory.
    localparam logic [3:0] EXC_BIT_ADEF   = 4'd0;
    localparam logic [3:0] EXC_BIT_TLBR_F = 4'd1;
    localparam logic [3:0] EXC_BIT_PIF    = 4'd2;
    localparam logic [3:0] EXC_BIT_PPI_F  = 4'd3;
    localparam logic [3:0] EXC_BIT_INE    = 4'd4;
    localparam logic [3:0] EXC_BIT_IPE    = 4'd5;
    localparam logic [3:0] EXC_BIT_FPD    = 4'd6;
    localparam logic [3:0] EXC_BIT_SYS    = 4'd7;
    localparam logic [3:0] EXC_BIT_BRK    = 4'd8;
    localparam logic [3:0] EXC_BIT_ADEM   = 4'd9;
    localparam logic [3:0] EXC_BIT_ALE    = 4'd10;
    localparam logic [3:0] EXC_BIT_TLBR_M = 4'd11;
    localparam logic [3:0] EXC_BIT_PIL    = 4'd12;
    localparam logic [3:0] EXC_BIT_PIS    = 4'd13;
    localparam logic [3:0] EXC_BIT_PME    = 4'd14;
    localparam logic [3:0] EXC_BIT_PPI_M  = 4'd15;

    function automatic logic [EXC_CAUSE_W-1:0] exc_bit_to_cause(input logic [3:0] idx);
        logic [EXC_CAUSE_W-1:0] c;
        case (idx)
            EXC_BIT_ADEF:   c = EXCEPTION_ADE;
            EXC_BIT_TLBR_F: c = EXCEPTION_TLBR;
            EXC_BIT_PIF:    c = EXCEPTION_PIF;
            EXC_BIT_PPI_F:  c = EXCEPTION_PPI;
            EXC_BIT_INE:    c = EXCEPTION_INE;
            EXC_BIT_IPE:    c = EXCEPTION_IPE;
            EXC_BIT_FPD:    c = EXCEPTION_FPD;
            EXC_BIT_SYS:    c = EXCEPTION_SYS;
            EXC_BIT_BRK:    c = EXCEPTION_BRK;
            EXC_BIT_ADEM:   c = EXCEPTION_ADE;
            EXC_BIT_ALE:    c = EXCEPTION_ALE;
            EXC_BIT_TLBR_M: c = EXCEPTION_TLBR;
            EXC_BIT_PIL:    c = EXCEPTION_PIL;
            EXC_BIT_PIS:    c = EXCEPTION_PIS;
            EXC_BIT_PME:    c = EXCEPTION_PME;
            EXC_BIT_PPI_M:  c = EXCEPTION_PPI;
            default:        c = EXCEPTION_INT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - combinational priority encoder, lowest set flag index wins
module exc_prio_enc
    import exception_ctrl_pkg::*;
#(
    parameter int N_EXC = N_EXC_DEF
) (
    input  logic [N_EXC-1:0]       exc_i,
    output logic                   any_o,
    output logic [EXC_CAUSE_W-1:0] cause_o
);

    // Scan from the lowest-priority end so the highest-priority flag overwrites last.
    always_comb begin
        cause_o = EXCEPTION_INT;
        for (int i = N_EXC - 1; i >= 0; i--) begin
            if (exc_i[i]) begin
                cause_o = exc_bit_to_cause(4'(i));
            end
        end
    end

    assign any_o = |exc_i;

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - commit-stage exception/interrupt/ERTN arbiter driving CSR pulses and redirect
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter int N_EXC  = N_EXC_DEF,
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   commit_valid,
    output logic                   commit_ready,
    input  logic [ADDR_W-1:0]      commit_pc,
    input  logic [N_EXC-1:0]       commit_exc,
    input  logic [ADDR_W-1:0]      commit_bad_addr,
    input  logic                   commit_is_ertn,
    input  logic                   crmd_ie,
    input  logic [11:0]            ecfg_lie,
    input  logic [11:0]            estat_is,
    input  logic [ADDR_W-1:0]      eentry_va,
    input  logic [ADDR_W-1:0]      tlbrentry_pa,
    input  logic [ADDR_W-1:0]      era_pc,
    output logic                   is_exception,
    output logic [EXC_CAUSE_W-1:0] exception_cause,
    output logic [ADDR_W-1:0]      exception_pc,
    output logic [ADDR_W-1:0]      exception_addr,
    output logic                   is_ertn,
    output logic                   is_syscall_break,
    output logic                   flush,
    output logic                   redirect_valid,
    output logic [ADDR_W-1:0]      redirect_pc,
    input  logic                   redirect_ready
);

    exc_state_e             state_q, state_d;
    logic                   int_pend_q, int_pend_d;
    logic                   is_exc_q, is_exc_d;
    logic                   is_ertn_q, is_ertn_d;
    logic                   sysbrk_q, sysbrk_d;
    logic                   flush_q, flush_d;
    logic                   rv_q, rv_d;
    logic [EXC_CAUSE_W-1:0] cause_q, cause_d;
    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W-1:0]      rpc_q, rpc_d;

    logic                   exc_any;
    logic [EXC_CAUSE_W-1:0] exc_cause;
    logic                   commit_fire;

    exc_prio_enc #(
        .N_EXC (N_EXC)
    ) u_prio_enc (
        .exc_i   (commit_exc),
        .any_o   (exc_any),
        .cause_o (exc_cause)
    );

    assign commit_ready = (state_q == ST_IDLE);
    assign commit_fire  = commit_valid && commit_ready;

    always_comb begin
        state_d    = state_q;
        int_pend_d = (state_q != ST_REDIRECT) && crmd_ie && (|(ecfg_lie & estat_is));
        is_exc_d   = 1'b0;
        is_ertn_d  = 1'b0;
        sysbrk_d   = 1'b0;
        flush_d    = flush_q;
        rv_d       = rv_q;
        cause_d    = cause_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        rpc_d      = rpc_q;

        case (state_q)
            ST_IDLE: begin
                if (commit_fire && (int_pend_q || exc_any || commit_is_ertn)) begin
                    state_d = ST_EVENT;
                    flush_d = 1'b1;
                    pc_d    = commit_pc;
                    addr_d  = commit_bad_addr;
                    if (int_pend_q) begin
                        is_exc_d = 1'b1;
                        cause_d  = EXCEPTION_INT;
                    end else if (exc_any) begin
                        // Exception flags beat ERTN, so a faulting ERTN never returns.
                        is_exc_d = 1'b1;
                        cause_d  = exc_cause;
                        sysbrk_d = (exc_cause == EXCEPTION_SYS) || (exc_cause == EXCEPTION_BRK);
                    end else begin
                        is_ertn_d = 1'b1;
                    end
                end
            end
            ST_EVENT: begin
                // CSR updates on this same edge, so ERA/EENTRY here are still the pre-event values.
                state_d = ST_REDIRECT;
                rv_d    = 1'b1;
                if (is_ertn_q) begin
                    rpc_d = era_pc;
                end else if (cause_q == EXCEPTION_TLBR) begin
                    rpc_d = tlbrentry_pa;
                end else begin
                    rpc_d = eentry_va;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                    flush_d = 1'b0;
                    rv_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                flush_d = 1'b0;
                rv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            int_pend_q <= 1'b0;
            is_exc_q   <= 1'b0;
            is_ertn_q  <= 1'b0;
            sysbrk_q   <= 1'b0;
            flush_q    <= 1'b0;
            rv_q       <= 1'b0;
            cause_q    <= '0;
            pc_q       <= '0;
            addr_q     <= '0;
            rpc_q      <= '0;
        end else begin
            state_q    <= state_d;
            int_pend_q <= int_pend_d;
            is_exc_q   <= is_exc_d;
            is_ertn_q  <= is_ertn_d;
            sysbrk_q   <= sysbrk_d;
            flush_q    <= flush_d;
            rv_q       <= rv_d;
            cause_q    <= cause_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            rpc_q      <= rpc_d;
        end
    end

    assign is_exception     = is_exc_q;
    assign is_ertn          = is_ertn_q;
    assign is_syscall_break = sysbrk_q;
    assign flush            = flush_q;
    assign redirect_valid   = rv_q;
    assign exception_cause  = cause_q;
    assign exception_pc     = pc_q;
    assign exception_addr   = addr_q;
    assign redirect_pc      = rpc_q;

endmodule
